fp_result_collector: RTL and testbench
======================================

Name: fp_result_collector

Overview:
Sink-side companion to the FP adder/multiplier units (fpadd, FP_multiplier). It consumes their result stream (product + valid_out, no back-pressure), buffers results in a FIFO, and tags frame boundaries. Results are presented to a ready/valid consumer such as a writeback or next-layer stage. One frame is FRAME_LEN results, normally (IMG_WIDTH*IMG_HEIGHT)/2, i.e. one result per operand pair.

Parameters:
DATA_WIDTH, 32, result word width (IEEE-754 single).
DEPTH, 16, FIFO entries; must be a power of two and at least 2.
ADDR_WIDTH, 4, log2(DEPTH).
FRAME_LEN, 18, results per frame; valid range 1..65535.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous reset, active-high.
valid_in  input  1  result valid from the FP unit (the unit's valid_out).
data_in  input  DATA_WIDTH  result word from the FP unit (the unit's product).
out_ready  input  1  consumer accepts data_out this cycle.
out_valid  output  1  data_out holds a buffered result.
data_out  output  DATA_WIDTH  head-of-FIFO result.
out_last  output  1  head word is the last word of a frame.
frame_done  output  1  one-cycle pulse: the last word of a frame was handshaken.
count  output  ADDR_WIDTH+1  current FIFO occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
overflow  output  1  sticky: a result was dropped because the FIFO was full.
nan_seen  output  1  sticky: an accepted result was NaN.

Behaviour:
- Reset (synchronous, high) clears the pointers, count, frame counter, frame_done, overflow and nan_seen. After reset: out_valid=0, empty=1, full=0, count=0, out_last=0. data_out is don't-care while out_valid=0. Memory contents are not cleared. A reset mid-frame discards all buffered words and the partial frame count.
- FIFO storage is DATA_WIDTH+1 bits per entry: the data word plus a last flag. The FIFO is first-word-fall-through. out_valid = !empty. data_out and out_last read combinationally from the read-pointer entry.
- Write: on any cycle with valid_in=1, the beat is written if the FIFO is not full, or if it is full and a read handshake occurs in the same cycle. Otherwise the word is dropped and overflow is set; it stays set until reset.
- Read: a handshake is out_valid & out_ready; it advances the read pointer. out_ready while empty has no effect.
- Simultaneous write and read: count is unchanged and both pointers advance. This holds when full and when count is 1. When empty, only the write takes effect and the read is ignored. The written word appears on data_out the following cycle; there is no same-cycle bypass.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH. count is tracked separately: +1 on write only, -1 on read only.
- Frame counter:
  - Counts every valid_in beat, whether written or dropped, from 0 to FRAME_LEN-1.
  - A beat arriving with counter == FRAME_LEN-1 is tagged last=1, and the counter wraps to 0 on that beat.
  - If a last beat is dropped, its flag is lost; overflow flags the error.
- frame_done is registered. It is 1 for exactly the cycle after a read handshake with out_last=1, and 0 otherwise.
- NaN check on written beats only: exponent bits [30:23] all ones and mantissa [22:0] nonzero sets nan_seen (sticky). Infinity does not set it.
- Latency: valid_in at edge N gives out_valid=1 after edge N when the FIFO was empty.
- No internal state machine beyond the FIFO and frame counter; all outputs are registered except data_out, out_last, out_valid, full and empty, which are decoded from registers.

Test Plan:
1. Reset, then feed 4 beats 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with out_ready=0 -> count=4. Then raise out_ready -> data_out reads them in order over 4 cycles, then empty=1 and count=0.
2. FRAME_LEN=3, stream 6 beats with out_ready=1 -> out_last=1 on the 3rd and 6th words; frame_done pulses twice, each one cycle after the corresponding handshake.
3. DEPTH=16, out_ready=0, 18 beats -> full=1, count=16, overflow=1. Beats 17 and 18 are absent; the drained sequence equals beats 1-16.
4. FIFO full and valid_in=1 with out_ready=1 in the same cycle -> no drop, overflow stays 0, count stays 16, pointers wrap correctly over 3 further cycles.
5. Input 0x7FC00000 -> nan_seen=1 and stays 1. Input 0x7F800000 alone after reset -> nan_seen=0.
6. Assert reset for one cycle mid-frame with count=5 and overflow=1 -> next cycle count=0, empty=1, overflow=0. The next FRAME_LEN beats form a full frame with last on beat FRAME_LEN.

Source files
------------

// File: rtl/fp_result_collector.sv
// Result sink for the FP adder/multiplier stream: first-word-fall-through FIFO
// with per-word frame-end tagging, a frame-done pulse and sticky error flags.
module fp_result_collector #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FRAME_LEN  = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_last,
    output logic                  frame_done,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  nan_seen
);

    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned EW    = DATA_WIDTH + 1;
    localparam int unsigned FCW   = 16;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           frame_done_q, frame_done_d;
    logic           overflow_q, overflow_d;
    logic           nan_seen_q, nan_seen_d;

    logic           empty_c;
    logic           full_c;
    logic           rd_fire_c;
    logic           wr_fire_c;
    logic           beat_last_c;
    logic           is_nan_c;
    logic [EW-1:0]  head_c;

    assign empty_c     = (count_q == CW'(0));
    assign full_c      = (count_q == CW'(DEPTH));
    assign rd_fire_c   = !empty_c && out_ready;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign wr_fire_c   = valid_in && (!full_c || rd_fire_c);
    assign beat_last_c = (frame_cnt_q == FCW'(FRAME_LEN - 1));
    assign is_nan_c    = (data_in[MAN_W +: EXP_W] == {EXP_W{1'b1}}) &&
                         (data_in[MAN_W-1:0] != {MAN_W{1'b0}});
    assign head_c      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        nan_seen_d   = nan_seen_q;

        if (wr_fire_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_fire_c) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            frame_done_d = head_c[DATA_WIDTH];
        end

        case ({wr_fire_c, rd_fire_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Every beat advances the frame position, even ones that get dropped.
        if (valid_in) begin
            frame_cnt_d = beat_last_c ? FCW'(0) : frame_cnt_q + FCW'(1);
            if (!wr_fire_c) begin
                overflow_d = 1'b1;
            end
        end
        if (wr_fire_c && is_nan_c) begin
            nan_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            nan_seen_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            nan_seen_q   <= nan_seen_d;
        end
    end

    // Storage is not reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire_c) begin
            mem_q[wr_ptr_q] <= {beat_last_c, data_in};
        end
    end

    assign out_valid  = !empty_c;
    assign data_out   = head_c[DATA_WIDTH-1:0];
    assign out_last   = head_c[DATA_WIDTH];
    assign frame_done = frame_done_q;
    assign count      = count_q;
    assign full       = full_c;
    assign empty      = empty_c;
    assign overflow   = overflow_q;
    assign nan_seen   = nan_seen_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// Bench for fp_result_collector: vector table plus hand sequences, all checked
// against a queue-based scoreboard of the expected FIFO contents.
module tb_fp_result_collector;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned FL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] data_out;
    logic          out_last;
    logic          frame_done;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          nan_seen;

    fp_result_collector #(
        .DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW), .FRAME_LEN(FL)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .out_ready(out_ready), .out_valid(out_valid), .data_out(data_out),
        .out_last(out_last), .frame_done(frame_done), .count(count),
        .full(full), .empty(empty), .overflow(overflow), .nan_seen(nan_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        int            exp_count;
        logic          exp_nan;
    } vec_t;

    // Scoreboard: entries are {last, data}, head at index 0.
    logic [DW:0] sb_q[$];
    int          m_fcnt;
    logic        m_ovf;
    logic        m_nan;
    logic        m_fdone;

    int n_vec  = 0;
    int n_miss = 0;
    int fd_pulses;
    int last_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_nan(input logic [DW-1:0] d);
        return (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
    endfunction

    task automatic check_state();
        logic [DW:0] head;
        check("count", 64'(count), 64'(sb_q.size()));
        check("empty", 64'(empty), 64'(sb_q.size() == 0));
        check("full", 64'(full), 64'(sb_q.size() == DP));
        check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("nan_seen", 64'(nan_seen), 64'(m_nan));
        check("frame_done", 64'(frame_done), 64'(m_fdone));
        if (frame_done === 1'b1) fd_pulses++;
        if (sb_q.size() != 0) begin
            head = sb_q[0];
            check("data_out", 64'(data_out), 64'(head[DW-1:0]));
            check("out_last", 64'(out_last), 64'(head[DW]));
        end
    endtask

    // Drive one cycle from the negedge, advance the model, check after the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
        logic        rd;
        logic        wr;
        logic        lst;
        logic [DW:0] head;
        valid_in  = v;
        data_in   = d;
        out_ready = r;
        rd  = (sb_q.size() != 0) && r;
        wr  = v && ((sb_q.size() < DP) || rd);
        lst = (m_fcnt == FL - 1);
        m_fdone = 1'b0;
        if (rd) begin
            head = sb_q.pop_front();
            m_fdone = head[DW];
            if (head[DW]) last_seen++;
        end
        if (v) begin
            m_fcnt = lst ? 0 : m_fcnt + 1;
            if (wr) sb_q.push_back({lst, d});
            else m_ovf = 1'b1;
        end
        if (wr && is_nan(d)) m_nan = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset();
        valid_in  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        m_fcnt  = 0;
        m_ovf   = 1'b0;
        m_nan   = 1'b0;
        m_fdone = 1'b0;
        check_state();
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 32'h3F80_0000, 1'b0, 1, 1'b0};
        vecs[1]  = '{1'b1, 32'h4000_0000, 1'b0, 2, 1'b0};
        vecs[2]  = '{1'b1, 32'h4040_0000, 1'b0, 3, 1'b0};
        vecs[3]  = '{1'b1, 32'h4080_0000, 1'b0, 4, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 3, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 2, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 1, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 0, 1'b0};
        vecs[8]  = '{1'b1, 32'h7F80_0000, 1'b0, 1, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 0, 1'b0};
        vecs[10] = '{1'b1, 32'h7FC0_0000, 1'b0, 1, 1'b1};
        vecs[11] = '{1'b0, 32'h0,         1'b1, 0, 1'b1};
        vecs[12] = '{1'b0, 32'h0,         1'b0, 0, 1'b1};

        fd_pulses = 0;
        last_seen = 0;
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        m_fcnt = 0; m_ovf = 1'b0; m_nan = 1'b0; m_fdone = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check_state();

        // Buffered order, drain, infinity vs NaN.
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].r);
            check("tbl_count", 64'(count), 64'(vecs[i].exp_count));
            check("tbl_nan", 64'(nan_seen), 64'(vecs[i].exp_nan));
        end

        // Streaming frames with consumer always ready.
        do_reset();
        fd_pulses = 0;
        last_seen = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'h4100_0000 + 32'(i), 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b1);
        check("frame_done_pulses", 64'(fd_pulses), 64'd2);
        check("last_words", 64'(last_seen), 64'd2);

        // Overfill: beats 17 and 18 dropped, drain returns beats 1-16.
        do_reset();
        for (int i = 0; i < 18; i++) cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_count", 64'(count), 64'd16);
        check("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check("drain_word", 64'(data_out), 64'(32'h1000_0000 + 32'(i)));
            cycle(1'b0, '0, 1'b1);
        end
        check("drain_empty", 64'(empty), 64'd1);

        // Full with simultaneous write and read: nothing dropped, pointers wrap.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h2000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h2100_0000 + 32'(i), 1'b1);
        check("rw_full_count", 64'(count), 64'd16);
        check("rw_full_ovf", 64'(overflow), 64'd0);
        check("rw_full_head", 64'(data_out), 64'h2000_0003);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        // Single-entry simultaneous write/read, then write/read on empty.
        cycle(1'b1, 32'h3000_0000, 1'b0);
        cycle(1'b1, 32'h3000_0001, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h3000_0002, 1'b1);
        check("empty_rw_count", 64'(count), 64'd1);
        cycle(1'b0, '0, 1'b1);

        // Mid-frame reset with count 5 and overflow set.
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 11; i++) cycle(1'b0, '0, 1'b1);
        check("pre_rst_count", 64'(count), 64'd5);
        check("pre_rst_ovf", 64'(overflow), 64'd1);
        do_reset();
        check("post_rst_count", 64'(count), 64'd0);
        check("post_rst_empty", 64'(empty), 64'd1);
        check("post_rst_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < FL; i++) cycle(1'b1, 32'h6000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < FL; i++) begin
            check("new_frame_last", 64'(out_last), 64'(i == FL - 1));
            cycle(1'b0, '0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
